// File: rtl/ppm_mary_tx.sv
// M-ary pulse-position modulator: one low pulse per symbol frame, slot = symbol.
// Build option: define PPM_GRAY_EN to Gray-map the symbol onto the slot index.
module ppm_mary_tx #(
  parameter int M_BITS      = 2,
  parameter int SLOT_CYCLES = 16,
  parameter int GUARD_SLOTS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [M_BITS-1:0] sym_data,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              ppm,
  output logic              sym_done,
  output logic              busy
);

  localparam int M     = 1 << M_BITS;
  localparam int SLOTS = M + GUARD_SLOTS;
  localparam int CW    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FRAME = 2'b01;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [M_BITS-1:0] sym_q, sym_d;
  logic              ppm_q, ppm_d;

  logic in_frame;
  logic cyc_end;
  logic last;
  logic accept;

  function automatic logic [SW-1:0] target(input logic [M_BITS-1:0] s);
    logic [M_BITS-1:0] g;
`ifdef PPM_GRAY_EN
    g = s ^ (s >> 1);
`else
    g = s;
`endif
    return SW'(g);
  endfunction

  assign in_frame  = (state_q == ST_FRAME);
  assign cyc_end   = (cyc_q == CYC_LAST);
  assign last      = in_frame & cyc_end & (slot_q == SLOT_LAST);
  assign sym_ready = (state_q == ST_IDLE) | last;
  assign accept    = sym_valid & sym_ready;
  assign sym_done  = last;
  assign busy      = in_frame;
  assign ppm       = ppm_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    sym_d   = sym_q;
    if (accept) begin
      state_d = ST_FRAME;
      cyc_d   = '0;
      slot_d  = '0;
      sym_d   = sym_data;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FRAME: begin
          if (last) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            slot_d  = '0;
          end else if (cyc_end) begin
            cyc_d  = '0;
            slot_d = slot_q + 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          slot_d  = '0;
        end
      endcase
    end
    // ppm is registered, so it is computed from next-cycle position
    ppm_d = !((state_d == ST_FRAME) && (slot_d == target(sym_d)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      slot_q  <= '0;
      sym_q   <= '0;
      ppm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      sym_q   <= sym_d;
      ppm_q   <= ppm_d;
    end
  end

endmodule

// File: tb/tb_ppm_mary_tx.sv
// Bench for ppm_mary_tx: default instance plus M_BITS=3/SLOT=4/GUARD=2 instance.
// Expected per-cycle outputs are queued at acceptance and popped every cycle.
module tb_ppm_mary_tx;

  typedef struct {
    bit ppm;
    bit done;
    bit ready;
    bit busy;
  } exp_t;

  typedef struct {
    int d;
    int sym;
    int lo;
    int hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sd0 = '0;
  logic [2:0] sd1 = '0;
  logic sv0 = 1'b0;
  logic sv1 = 1'b0;
  logic rdy0, ppm0, done0, busy0;
  logic rdy1, ppm1, done1, busy1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  ppm_mary_tx u0 (
    .clk(clk), .rst_n(rst_n),
    .sym_data(sd0), .sym_valid(sv0), .sym_ready(rdy0),
    .ppm(ppm0), .sym_done(done0), .busy(busy0)
  );

  ppm_mary_tx #(.M_BITS(3), .SLOT_CYCLES(4), .GUARD_SLOTS(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .sym_data(sd1), .sym_valid(sv1), .sym_ready(rdy1),
    .ppm(ppm1), .sym_done(done1), .busy(busy1)
  );

  function automatic int flen(int d);
    return (d == 0) ? 64 : 40;
  endfunction

  task automatic cmp(int d, exp_t e, bit p, bit dn, bit r, bit b);
    total++;
    if (p !== e.ppm || dn !== e.done || r !== e.ready || b !== e.busy) begin
      bad++;
      $display("FAIL cyc d=%0d t=%0t ppm/done/ready/busy got=%b%b%b%b want=%b%b%b%b",
               d, $time, p, dn, r, b, e.ppm, e.done, e.ready, e.busy);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e0, e1;
      e0 = '{ppm: 1'b1, done: 1'b0, ready: 1'b1, busy: 1'b0};
      e1 = e0;
      if (q0.size() > 0) e0 = q0.pop_front();
      if (q1.size() > 0) e1 = q1.pop_front();
      cmp(0, e0, ppm0, done0, rdy0, busy0);
      cmp(1, e1, ppm1, done1, rdy1, busy1);
    end
  end

  task automatic push_frame(int d, int lo, int hi);
    int n;
    n = flen(d);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.ppm   = !(k >= lo && k <= hi);
      e.done  = (k == n - 1);
      e.ready = (k == n - 1);
      e.busy  = 1'b1;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // returns at acceptance edge + #1, i.e. inside frame cycle 0
  task automatic offer(int d, int sym, int lo, int hi, bit hold);
    int n;
    bit r;
    n = 0;
    if (d == 0) begin sd0 = 2'(sym); sv0 = 1'b1; end
    else begin sd1 = 3'(sym); sv1 = 1'b1; end
    @(negedge clk);
    r = (d == 0) ? rdy0 : rdy1;
    while (!r && n < 300) begin
      @(negedge clk);
      r = (d == 0) ? rdy0 : rdy1;
      n++;
    end
    if (!r) begin
      total++;
      bad++;
      $display("FAIL accept_timeout d=%0d sym=%0d got ready=0 want ready=1", d, sym);
      sv0 = 1'b0;
      sv1 = 1'b0;
      return;
    end
    @(posedge clk);
    push_frame(d, lo, hi);
    #1;
    if (!hold) begin
      if (d == 0) sv0 = 1'b0;
      else sv1 = 1'b0;
    end
  endtask

  initial begin
`ifdef PPM_GRAY_EN
    tbl[0] = '{0, 0, 0, 15};
    tbl[1] = '{0, 1, 16, 31};
    tbl[2] = '{0, 2, 48, 63};
    tbl[3] = '{0, 3, 32, 47};
    tbl[4] = '{1, 7, 16, 19};
    tbl[5] = '{1, 0, 0, 3};
    tbl[6] = '{1, 5, 28, 31};
`else
    tbl[0] = '{0, 0, 0, 15};
    tbl[1] = '{0, 1, 16, 31};
    tbl[2] = '{0, 2, 32, 47};
    tbl[3] = '{0, 3, 48, 63};
    tbl[4] = '{1, 7, 28, 31};
    tbl[5] = '{1, 0, 0, 3};
    tbl[6] = '{1, 5, 20, 23};
`endif

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      offer(tbl[i].d, tbl[i].sym, tbl[i].lo, tbl[i].hi, 1'b0);
      repeat (flen(tbl[i].d) + 3) @(posedge clk);
      #1;
    end

    // back-to-back symbols 3,1,2 with valid held high
`ifdef PPM_GRAY_EN
    offer(0, 3, 32, 47, 1'b1);
    offer(0, 1, 16, 31, 1'b1);
    offer(0, 2, 48, 63, 1'b0);
`else
    offer(0, 3, 48, 63, 1'b1);
    offer(0, 1, 16, 31, 1'b1);
    offer(0, 2, 32, 47, 1'b0);
`endif
    repeat (67) @(posedge clk);
    #1;

    // data/valid wiggle mid-frame must not move the pulse
    offer(0, 0, 0, 15, 1'b0);
    repeat (5) @(posedge clk);
    #1 sd0 = 2'd3;
    sv0 = 1'b1;
    @(posedge clk);
    #1 sv0 = 1'b0;
    repeat (62) @(posedge clk);
    #1;

    // back-to-back on the guarded instance
`ifdef PPM_GRAY_EN
    offer(1, 2, 12, 15, 1'b1);
    offer(1, 6, 20, 23, 1'b0);
`else
    offer(1, 2, 8, 11, 1'b1);
    offer(1, 6, 24, 27, 1'b0);
`endif
    repeat (43) @(posedge clk);
    #1;

    // one-cycle reset in frame cycle 10 aborts the frame
`ifdef PPM_GRAY_EN
    offer(0, 1, 16, 31, 1'b0);
`else
    offer(0, 1, 16, 31, 1'b0);
`endif
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q0.delete();
    q1.delete();
    repeat (4) @(posedge clk);
    #1;
`ifdef PPM_GRAY_EN
    offer(0, 2, 48, 63, 1'b0);
`else
    offer(0, 2, 32, 47, 1'b0);
`endif
    repeat (67) @(posedge clk);
    #1;

    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
